// File: rtl/cmos_sccb_config.sv
`timescale 1ns/1ps
// SCCB configuration master: sequences sensor power-up, then writes {reg,val}
// pairs from an external table until 16'hFFFF, with 16'hFFF0 as a delay entry.
module cmos_sccb_config #(
  parameter int unsigned CLK_HZ   = 10_000_000,
  parameter int unsigned SCCB_HZ  = 100_000,
  parameter logic [7:0]  DEV_ADDR = 8'h42,
  parameter int unsigned T_RST    = 10_000,
  parameter int unsigned T_INIT   = 10_000,
  parameter int unsigned T_DLY    = 100_000
) (
  input  logic        CLK_IN,
  input  logic        nRST,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic        CMOS_SIO_C,
  output logic        CMOS_SIO_D,
  output logic        CMOS_RESET,
  output logic        CMOS_PWDN,
  output logic [3:0]  dbg_state
);
  localparam int unsigned QDIV_RAW = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned QDIV     = (QDIV_RAW == 0) ? 1 : QDIV_RAW;
  localparam int unsigned QW       = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PWR_RST  = 4'd1,
    PWR_WAIT = 4'd2,
    FETCH    = 4'd3,
    START    = 4'd4,
    SHIFT    = 4'd5,
    STOP     = 4'd6,
    GAP      = 4'd7,
    DELAY    = 4'd8,
    DONE     = 4'd9
  } state_t;

  // Handshake: start is a level request honoured only in IDLE or DONE and
  // ignored otherwise; busy covers the whole run and done rises as busy falls.
  state_t        state_q;
  logic [1:0]    arm_q;
  logic [QW-1:0] qcnt_q;
  logic [31:0]   cnt_q;
  logic [1:0]    ph_q;
  logic [4:0]    bit_q;
  logic [26:0]   sh_q;
  logic [7:0]    addr_q;
  logic          sio_c_q, sio_d_q, rst_q, pwdn_q, busy_q, done_q;
  logic          tick, sccb_active;

  assign tick        = (qcnt_q == QW'(QDIV - 1));
  assign sccb_active = (state_q == START) || (state_q == SHIFT) ||
                       (state_q == STOP)  || (state_q == GAP);

  always_ff @(posedge CLK_IN or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      arm_q   <= 2'b00;
      qcnt_q  <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      sio_c_q <= 1'b1;
      sio_d_q <= 1'b1;
      rst_q   <= 1'b0;
      pwdn_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Reset release is retimed so the FSM only moves from the third edge on.
      arm_q <= {arm_q[0], 1'b1};
      if (arm_q[1]) begin
        if (sccb_active) qcnt_q <= tick ? '0 : qcnt_q + QW'(1);
        else             qcnt_q <= '0;
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              state_q <= PWR_RST;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              rst_q   <= 1'b0;
              pwdn_q  <= 1'b0;
              cnt_q   <= '0;
              addr_q  <= '0;
            end
          end
          PWR_RST: begin
            if (cnt_q == T_RST - 1) begin
              state_q <= PWR_WAIT;
              rst_q   <= 1'b1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 32'd1;
          end
          PWR_WAIT: begin
            if (cnt_q == T_INIT - 1) begin
              state_q <= FETCH;
              addr_q  <= '0;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 32'd1;
          end
          FETCH: begin
            // rom_data lags rom_addr by one cycle, so decide on the second cycle.
            if (cnt_q == 32'd0) cnt_q <= 32'd1;
            else begin
              cnt_q <= '0;
              if (addr_q == 8'hFF || rom_data == 16'hFFFF) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (rom_data == 16'hFFF0) begin
                state_q <= DELAY;
              end else begin
                state_q <= START;
                sh_q    <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                ph_q    <= '0;
                bit_q   <= '0;
              end
            end
          end
          START: begin
            if (tick) begin
              if (ph_q == 2'd0) begin
                sio_d_q <= 1'b0;
                ph_q    <= 2'd1;
              end else begin
                sio_c_q <= 1'b0;
                ph_q    <= 2'd0;
                state_q <= SHIFT;
              end
            end
          end
          SHIFT: begin
            if (tick) begin
              ph_q <= ph_q + 2'd1;
              case (ph_q)
                2'd0: begin
                  sio_c_q <= 1'b0;
                  sio_d_q <= sh_q[26];
                  sh_q    <= {sh_q[25:0], 1'b1};
                end
                2'd1: sio_c_q <= 1'b1;
                2'd2: sio_c_q <= 1'b1;
                default: begin
                  sio_c_q <= 1'b0;
                  if (bit_q == 5'd26) state_q <= STOP;
                  else bit_q <= bit_q + 5'd1;
                end
              endcase
            end
          end
          STOP: begin
            if (tick) begin
              case (ph_q)
                2'd0: begin
                  sio_d_q <= 1'b0;
                  ph_q    <= 2'd1;
                end
                2'd1: begin
                  sio_c_q <= 1'b1;
                  ph_q    <= 2'd2;
                end
                default: begin
                  sio_d_q <= 1'b1;
                  ph_q    <= 2'd0;
                  state_q <= GAP;
                end
              endcase
            end
          end
          GAP: begin
            if (tick) begin
              ph_q <= ph_q + 2'd1;
              if (ph_q == 2'd3) begin
                state_q <= FETCH;
                addr_q  <= addr_q + 8'd1;
                cnt_q   <= '0;
              end
            end
          end
          DELAY: begin
            if (cnt_q == T_DLY - 1) begin
              state_q <= FETCH;
              addr_q  <= addr_q + 8'd1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 32'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rom_addr   = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign CMOS_SIO_C = sio_c_q;
  assign CMOS_SIO_D = sio_d_q;
  assign CMOS_RESET = rst_q;
  assign CMOS_PWDN  = pwdn_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_cmos_sccb_config.sv
`timescale 1ns/1ps
// Bench for cmos_sccb_config: table runs, reset abort, reruns and an
// unterminated table on a second, fast-clocked instance.
module tb_cmos_sccb_config;
  localparam int T_RST   = 100;
  localparam int T_INIT  = 100;
  localparam int T_DLY   = 500;
  localparam int BIT_CYC = 100;
  // CMOS_RESET rise -> first SIO_D fall: T_INIT + 2 fetch cycles + one 25-cycle quarter.
  localparam int INIT_LAT = T_INIT + 2 + 25;
  // STOP end -> next START fall: 4-quarter gap (100) + 2 fetch + one quarter.
  localparam int GAP_LAT  = 100 + 2 + 25;
  // Each delay entry adds its own 2-cycle fetch plus T_DLY.
  localparam int DLY_COST = 2 + T_DLY;

  typedef struct {
    logic [3:0][15:0] ent;
    logic [7:0]       exp_addr;
    int               exp_txn;
    int               exp_init;
    int               exp_gap;
  } vec_t;

  logic        clk, nrst, start, f_start;
  logic [7:0]  rom_addr, f_addr;
  logic [15:0] rom_data, f_data;
  logic        busy, done, sio_c, sio_d, cmos_reset, cmos_pwdn;
  logic        f_busy, f_done, f_c, f_d, f_rst, f_pwdn;
  logic [3:0]  dbg_state, f_state;
  logic [15:0] tbl [256];
  vec_t        vecs [6];

  int checks = 0, failures = 0, cyc = 0;
  logic prev_c = 1'b1, prev_d = 1'b1, prev_rst = 1'b0;
  bit   in_frame = 0;
  int   bitcnt = 0, last_rise = -1, stop_cyc = -1, gap_meas = -1;
  int   first_start = -1, rst_rise = -1, rst_low = 0, pwdn_bad = 0;
  int   txn_cnt = 0, viol = 0, period_bad = 0, rec_sel = 0;
  logic [8:0] sh9 = '0;
  logic [8:0] exp_q [$];
  logic [1:0] wave_a [$];
  logic [1:0] wave_b [$];
  logic f_prev_c = 1'b1, f_prev_d = 1'b1, f_prev_busy = 1'b0;
  int   f_stops = 0, f_busy_rises = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmos_sccb_config #(
    .CLK_HZ(10_000_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
    .T_RST(T_RST), .T_INIT(T_INIT), .T_DLY(T_DLY)
  ) u_dut (
    .CLK_IN(clk), .nRST(nrst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .CMOS_SIO_C(sio_c), .CMOS_SIO_D(sio_d),
    .CMOS_RESET(cmos_reset), .CMOS_PWDN(cmos_pwdn), .dbg_state(dbg_state)
  );

  // One quarter per clock, so 255 transactions fit in a short run.
  cmos_sccb_config #(
    .CLK_HZ(400_000), .SCCB_HZ(100_000), .DEV_ADDR(8'h42),
    .T_RST(4), .T_INIT(4), .T_DLY(8)
  ) u_fast (
    .CLK_IN(clk), .nRST(nrst), .start(f_start), .rom_addr(f_addr), .rom_data(f_data),
    .busy(f_busy), .done(f_done), .CMOS_SIO_C(f_c), .CMOS_SIO_D(f_d),
    .CMOS_RESET(f_rst), .CMOS_PWDN(f_pwdn), .dbg_state(f_state)
  );

  always @(posedge clk) rom_data <= tbl[rom_addr];
  always @(posedge clk) f_data <= {8'h10, f_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3, input logic [7:0] a,
                              input int t, input int i, input int g);
    vec_t v;
    v.ent[0] = e0; v.ent[1] = e1; v.ent[2] = e2; v.ent[3] = e3;
    v.exp_addr = a; v.exp_txn = t; v.exp_init = i; v.exp_gap = g;
    return v;
  endfunction

  // Advance to the next falling edge and update the bus monitor and scoreboard.
  task automatic step();
    logic [8:0] exp;
    @(negedge clk);
    cyc++;
    if (!nrst) begin
      in_frame = 0; bitcnt = 0; last_rise = -1;
      exp_q.delete();
    end else begin
      if (prev_c && sio_c && prev_d && !sio_d) begin
        if (in_frame) viol++;
        in_frame = 1; bitcnt = 0; last_rise = -1;
        if (first_start < 0) first_start = cyc;
        if (stop_cyc >= 0) gap_meas = cyc - stop_cyc;
      end
      if (prev_c && sio_c && !prev_d && sio_d) begin
        if (!in_frame || bitcnt != 27) viol++;
        in_frame = 0; txn_cnt++; stop_cyc = cyc;
      end
      if (!prev_c && sio_c && in_frame && bitcnt < 27) begin
        if (last_rise >= 0 && cyc - last_rise != BIT_CYC) period_bad++;
        last_rise = cyc;
        sh9 = {sh9[7:0], sio_d};
        bitcnt++;
        if (bitcnt % 9 == 0) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sccb_byte actual=0x%0h required=none", sh9);
          end else begin
            exp = exp_q.pop_front();
            check("sccb_byte", 32'(sh9), 32'(exp));
          end
        end
      end
      if (busy && !cmos_reset) rst_low++;
      if (!prev_rst && cmos_reset && busy) rst_rise = cyc;
      if (busy && cmos_pwdn) pwdn_bad++;
      if (busy && rec_sel == 1) wave_a.push_back({sio_c, sio_d});
      if (busy && rec_sel == 2) wave_b.push_back({sio_c, sio_d});
    end
    prev_c = sio_c; prev_d = sio_d; prev_rst = cmos_reset;
    if (f_prev_c && f_c && !f_prev_d && f_d) f_stops++;
    if (!f_prev_busy && f_busy) f_busy_rises++;
    f_prev_c = f_c; f_prev_d = f_d; f_prev_busy = f_busy;
  endtask

  task automatic load_and_expect(input int vi);
    bit ended;
    logic [15:0] e;
    for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;
    for (int k = 0; k < 4; k++) tbl[k] = vecs[vi].ent[k];
    ended = 0;
    for (int k = 0; k < 4; k++) begin
      e = vecs[vi].ent[k];
      if (e == 16'hFFFF) ended = 1;
      if (!ended && e != 16'hFFF0) begin
        exp_q.push_back({8'h42, 1'b1});
        exp_q.push_back({e[15:8], 1'b1});
        exp_q.push_back({e[7:0], 1'b1});
      end
    end
    txn_cnt = 0; viol = 0; period_bad = 0; stop_cyc = -1; gap_meas = -1;
    first_start = -1; rst_rise = -1; rst_low = 0; pwdn_bad = 0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 8) begin step(); n++; end
    start = 1'b0;
    check("start_accept", 32'(busy), 32'd1);
  endtask

  task automatic finish_run(input int vi);
    int n = 0;
    while (!done && n < 20000) begin step(); n++; end
    check("run_done", 32'(done), 32'd1);
    check("busy_clear", 32'(busy), 32'd0);
    check("final_rom_addr", 32'(rom_addr), 32'(vecs[vi].exp_addr));
    check("txn_count", txn_cnt, vecs[vi].exp_txn);
    check("sb_empty", exp_q.size(), 0);
    check("reset_low_cycles", rst_low, T_RST);
    check("pwdn_while_busy", pwdn_bad, 0);
    check("sccb_protocol", viol, 0);
    check("bit_period", period_bad, 0);
    check("done_lines", 32'({sio_c, sio_d, cmos_reset, cmos_pwdn}), 32'h0000_000E);
    if (vecs[vi].exp_init > 0) check("init_to_start", first_start - rst_rise, vecs[vi].exp_init);
    if (vecs[vi].exp_gap > 0) check("txn_gap", gap_meas, vecs[vi].exp_gap);
  endtask

  initial begin
    int n, ndiff;
    vecs[0] = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd1, 1, INIT_LAT, 0);
    vecs[1] = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd1, 1, INIT_LAT, 0);
    vecs[2] = mk(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF, 8'd3, 2, INIT_LAT, GAP_LAT + DLY_COST);
    vecs[3] = mk(16'hFFFF, 16'h1280, 16'h1280, 16'hFFFF, 8'd0, 0, 0, 0);
    vecs[4] = mk(16'hFFF0, 16'hFFF0, 16'h3456, 16'hFFFF, 8'd3, 1, INIT_LAT + 2 * DLY_COST, 0);
    vecs[5] = mk(16'hABCD, 16'h0000, 16'hFFFF, 16'hFFFF, 8'd2, 2, INIT_LAT, GAP_LAT);
    for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;

    nrst = 1'b0; start = 1'b0; f_start = 1'b0;
    repeat (3) step();
    check("reset_outputs", 32'({sio_c, sio_d, cmos_reset, cmos_pwdn, busy, done, rom_addr}),
          32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    check("reset_state_idle", 32'({dbg_state, f_state}), 32'h0000_0000);
    check("reset_fast_outputs", 32'({f_c, f_d, f_rst, f_pwdn, f_busy, f_done, f_addr}),
          32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    nrst = 1'b1;
    repeat (10) step();
    check("idle_holds", 32'({busy, done, cmos_reset, cmos_pwdn}), 32'h0000_0001);

    for (int vi = 0; vi < 6; vi++) begin
      rec_sel = (vi < 2) ? vi + 1 : 0;
      load_and_expect(vi);
      start = 1'b1;
      wait_busy();
      finish_run(vi);
      repeat (5) step();
    end
    rec_sel = 0;
    ndiff = 0;
    for (int i = 0; i < wave_a.size() && i < wave_b.size(); i++)
      if (wave_a[i] !== wave_b[i]) ndiff++;
    check("rerun_wave_len", wave_b.size(), wave_a.size());
    check("rerun_wave_diff", ndiff, 0);

    // Abort in the middle of bit 10, then restart with start already high at release.
    load_and_expect(0);
    start = 1'b1;
    wait_busy();
    n = 0;
    while (bitcnt < 10 && n < 5000) begin step(); n++; end
    check("reach_bit10", 32'(bitcnt >= 10), 32'd1);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 check("abort_outputs", 32'({sio_c, sio_d, cmos_reset, cmos_pwdn, busy, done, rom_addr}),
             32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    repeat (2) step();
    load_and_expect(0);
    nrst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 check("release_first_edge", 32'(busy), 32'd0);
    wait_busy();
    finish_run(0);

    // Unterminated table with start held high for the whole run.
    f_start = 1'b1;
    n = 0;
    while (!f_done && n < 40000) begin step(); n++; end
    f_start = 1'b0;
    check("fast_done", 32'(f_done), 32'd1);
    check("fast_txn_count", f_stops, 255);
    check("fast_rom_addr", 32'(f_addr), 32'h0000_00FF);
    check("fast_single_run", f_busy_rises, 1);
    repeat (4) step();
    check("fast_no_restart", 32'({f_busy, f_done, f_c, f_d}), 32'h0000_0007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
